// File: rtl/mem_req_responder.sv
// Memory request responder: turns one 1- or 2-byte request from the control unit
// into byte-wide single-beat Wishbone-style transfers and returns data, done and error.
module mem_req_responder #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic              req_double,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [15:0]       rsp_rdata,
    output logic              rsp_error,
    output logic              bus_cyc,
    output logic              bus_stb,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_adr,
    output logic [7:0]        bus_dat_o,
    input  logic [7:0]        bus_dat_i,
    input  logic              bus_ack
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state;
    logic             double_q;
    logic [7:0]       wdata_hi;
    logic [CNT_W-1:0] beat_cnt;
    logic             timeout_hit;

    // The last unacknowledged cycle of a beat; an ack on that same edge still wins.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (beat_cnt == LIMIT);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            double_q  <= 1'b0;
            wdata_hi  <= 8'h00;
            beat_cnt  <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 16'h0000;
            rsp_error <= 1'b0;
            bus_cyc   <= 1'b0;
            bus_stb   <= 1'b0;
            bus_we    <= 1'b0;
            bus_adr   <= '0;
            bus_dat_o <= 8'h00;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state     <= BEAT0;
                        req_ready <= 1'b0;
                        double_q  <= req_double;
                        wdata_hi  <= req_wdata[15:8];
                        beat_cnt  <= '0;
                        rsp_rdata <= 16'h0000;
                        rsp_error <= 1'b0;
                        bus_cyc   <= 1'b1;
                        bus_stb   <= 1'b1;
                        bus_we    <= req_write;
                        bus_adr   <= req_addr;
                        bus_dat_o <= req_wdata[7:0];
                    end
                end

                BEAT0: begin
                    if (bus_ack) begin
                        if (!bus_we) begin
                            rsp_rdata[7:0] <= bus_dat_i;
                        end
                        if (double_q) begin
                            // Second beat follows with no idle gap; address wraps naturally.
                            state     <= BEAT1;
                            beat_cnt  <= '0;
                            bus_adr   <= bus_adr + 1'b1;
                            bus_dat_o <= wdata_hi;
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            bus_cyc   <= 1'b0;
                            bus_stb   <= 1'b0;
                            bus_we    <= 1'b0;
                            bus_adr   <= '0;
                            bus_dat_o <= 8'h00;
                        end
                    end else if (timeout_hit) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= 16'hFFFF;
                        rsp_error <= 1'b1;
                        bus_cyc   <= 1'b0;
                        bus_stb   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_adr   <= '0;
                        bus_dat_o <= 8'h00;
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end

                BEAT1: begin
                    if (bus_ack) begin
                        if (!bus_we) begin
                            rsp_rdata[15:8] <= bus_dat_i;
                        end
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        bus_cyc   <= 1'b0;
                        bus_stb   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_adr   <= '0;
                        bus_dat_o <= 8'h00;
                    end else if (timeout_hit) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= 16'hFFFF;
                        rsp_error <= 1'b1;
                        bus_cyc   <= 1'b0;
                        bus_stb   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_adr   <= '0;
                        bus_dat_o <= 8'h00;
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end

                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end

                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_responder.sv
// Self-checking bench for mem_req_responder: directed and randomized requests
// against a transaction-level expectation built from the request and bus responses.
module tb_mem_req_responder;

    localparam int T      = 16;
    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              nrst;
    logic              req_valid;
    logic              req_write;
    logic              req_double;
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [15:0]       rsp_rdata;
    logic              rsp_error;
    logic              bus_cyc;
    logic              bus_stb;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_adr;
    logic [7:0]        bus_dat_o;
    logic [7:0]        bus_dat_i;
    logic              bus_ack;

    int checks = 0;
    int errors = 0;

    mem_req_responder #(
        .TIMEOUT_CYCLES(T),
        .ADDR_W        (ADDR_W)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_double(req_double),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error),
        .bus_cyc   (bus_cyc),
        .bus_stb   (bus_stb),
        .bus_we    (bus_we),
        .bus_adr   (bus_adr),
        .bus_dat_o (bus_dat_o),
        .bus_dat_i (bus_dat_i),
        .bus_ack   (bus_ack)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One request from acceptance to the idle cycle after its response. A wait of
    // wN means wN cycles without ack before acking; wN >= T means never ack.
    task automatic apply_stimulus(input logic wr, input logic dbl, input logic [15:0] addr,
                                  input logic [15:0] wdata, input int w0, input int w1,
                                  input logic [7:0] d0, input logic [7:0] d1, input logic hold);
        logic [15:0] beat_adr[2];
        logic [7:0]  beat_dat[2];
        logic [7:0]  beat_rd[2];
        int          waits[2];
        int          nbeats;
        logic        timed_out;
        logic [15:0] exp_rdata;

        beat_adr[0] = addr;
        beat_adr[1] = addr + 16'd1;
        beat_dat[0] = wdata[7:0];
        beat_dat[1] = wdata[15:8];
        beat_rd[0]  = d0;
        beat_rd[1]  = d1;
        waits[0]    = w0;
        waits[1]    = w1;
        nbeats      = dbl ? 2 : 1;
        timed_out   = 1'b0;

        check_output("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_double = dbl;
        req_addr   = addr;
        req_wdata  = wdata;
        @(negedge clk);
        if (!hold) req_valid = 1'b0;

        for (int b = 0; b < nbeats && !timed_out; b++) begin
            for (int k = 0; k < T; k++) begin
                check_output("beat_cyc_stb", {30'd0, bus_cyc, bus_stb}, 32'd3);
                check_output("beat_adr", {16'd0, bus_adr}, {16'd0, beat_adr[b]});
                check_output("beat_we", {31'd0, bus_we}, {31'd0, wr});
                check_output("beat_dat_o", {24'd0, bus_dat_o}, {24'd0, beat_dat[b]});
                check_output("beat_rsp_ready_low", {30'd0, rsp_valid, req_ready}, 32'd0);
                if (k == waits[b]) begin
                    bus_ack   = 1'b1;
                    bus_dat_i = beat_rd[b];
                end else begin
                    bus_ack   = 1'b0;
                    bus_dat_i = 8'($urandom);
                end
                @(negedge clk);
                bus_ack = 1'b0;
                if (k == waits[b]) break;
                if (k == T - 1) timed_out = 1'b1;
            end
        end

        if (timed_out)      exp_rdata = 16'hFFFF;
        else if (wr)        exp_rdata = 16'h0000;
        else if (dbl)       exp_rdata = {d1, d0};
        else                exp_rdata = {8'h00, d0};

        check_output("rsp_valid_pulse", {31'd0, rsp_valid}, 32'd1);
        check_output("rsp_bus_idle", {30'd0, bus_cyc, bus_stb}, 32'd0);
        check_output("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, exp_rdata});
        check_output("rsp_error", {31'd0, rsp_error}, {31'd0, timed_out});

        bus_ack   = 1'($urandom_range(0, 1));
        bus_dat_i = 8'($urandom);
        @(negedge clk);
        bus_ack = 1'b0;
        check_output("after_rsp_valid_low", {31'd0, rsp_valid}, 32'd0);
        check_output("after_rsp_ready", {31'd0, req_ready}, 32'd1);
        check_output("after_rsp_stb", {31'd0, bus_stb}, 32'd0);
        check_output("hold_rdata", {16'd0, rsp_rdata}, {16'd0, exp_rdata});
        check_output("hold_error", {31'd0, rsp_error}, {31'd0, timed_out});
    endtask

    function automatic int pick_wait();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 7)       return r % 4;
        else if (r == 7) return T - 1;
        else if (r == 8) return T;
        else             return int'($urandom_range(4, T - 2));
    endfunction

    initial begin
        nrst       = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_double = 1'b0;
        req_addr   = '0;
        req_wdata  = 16'h0000;
        bus_dat_i  = 8'h00;
        bus_ack    = 1'b0;

        #12;
        check_output("reset_ready", {31'd0, req_ready}, 32'd1);
        check_output("reset_outputs", {28'd0, rsp_valid, rsp_error, bus_cyc, bus_stb}, 32'd0);
        check_output("reset_bus", {7'd0, bus_we, bus_adr, bus_dat_o}, 32'd0);
        check_output("reset_rdata", {16'd0, rsp_rdata}, 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        $display("[TB] directed requests");
        apply_stimulus(1'b0, 1'b0, 16'h1234, 16'h0000, 0, 0, 8'hA5, 8'h00, 1'b0);
        apply_stimulus(1'b0, 1'b1, 16'hFFFF, 16'h0000, 2, 2, 8'h34, 8'h12, 1'b0);
        apply_stimulus(1'b1, 1'b1, 16'h8000, 16'hBEEF, 0, 0, 8'h55, 8'h66, 1'b0);
        apply_stimulus(1'b0, 1'b1, 16'h4000, 16'h0000, T, T, 8'h11, 8'h22, 1'b0);
        apply_stimulus(1'b0, 1'b0, 16'h4000, 16'h0000, T - 1, 0, 8'h5A, 8'h00, 1'b0);
        apply_stimulus(1'b0, 1'b1, 16'h5000, 16'h0000, 1, T, 8'h77, 8'h88, 1'b0);
        apply_stimulus(1'b1, 1'b0, 16'h00FF, 16'h1357, T, 0, 8'h00, 8'h00, 1'b0);

        $display("[TB] back-to-back with req_valid held");
        apply_stimulus(1'b0, 1'b0, 16'h0100, 16'h0000, 0, 0, 8'hC3, 8'h00, 1'b1);
        apply_stimulus(1'b1, 1'b1, 16'h0200, 16'hCAFE, 1, 0, 8'h00, 8'h00, 1'b1);
        apply_stimulus(1'b0, 1'b1, 16'h0300, 16'h0000, 0, 3, 8'h9A, 8'hBC, 1'b0);

        $display("[TB] randomized requests");
        for (int i = 0; i < 40; i++) begin
            apply_stimulus(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                           pick_wait(), pick_wait(), 8'($urandom), 8'($urandom),
                           1'($urandom_range(0, 3) == 0));
            req_valid = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                for (int g = 0; g < 2; g++) begin
                    bus_ack   = 1'b1;
                    bus_dat_i = 8'($urandom);
                    @(negedge clk);
                    bus_ack = 1'b0;
                    check_output("idle_spurious_ack", {29'd0, bus_stb, rsp_valid, req_ready}, 32'd1);
                end
            end
        end

        $display("[TB] reset during second beat");
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_double = 1'b1;
        req_addr   = 16'h2222;
        @(negedge clk);
        req_valid = 1'b0;
        bus_ack   = 1'b1;
        bus_dat_i = 8'h44;
        @(negedge clk);
        bus_ack = 1'b0;
        check_output("beat1_before_reset", {15'd0, bus_stb, bus_adr}, {15'd0, 1'b1, 16'h2223});
        #2;
        nrst = 1'b0;
        #1;
        check_output("async_reset_bus", {30'd0, bus_cyc, bus_stb}, 32'd0);
        check_output("async_reset_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        nrst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_output("post_reset_quiet", {29'd0, rsp_valid, bus_stb, req_ready}, 32'd1);
        end
        apply_stimulus(1'b0, 1'b0, 16'h3333, 16'h0000, 0, 0, 8'h3C, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
